// File: rtl/zcache_if.sv
// zcache_if: bus bundle between the memory manager and zcache.
//   lu_*    : lookup request and registered result
//   fill_*  : DRAM read data returning on the CPU port
//   wr_*    : CPU byte write to RAM
//   flush_* : whole-cache invalidate request and busy status
// master = memory manager side, slave = cache side.
interface zcache_if #(
    parameter int unsigned ADDR_W = 21
);
    logic              lu_en;
    logic [ADDR_W-1:0] lu_addr;
    logic              lu_hit;
    logic [15:0]       lu_data;

    logic              fill_strobe;
    logic [ADDR_W-1:0] fill_addr;
    logic [15:0]       fill_data;

    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bsel;
    logic [7:0]        wr_data;

    logic              flush_req;
    logic              flush_busy;

    modport master (
        output lu_en, lu_addr,
        output fill_strobe, fill_addr, fill_data,
        output wr_strobe, wr_addr, wr_bsel, wr_data,
        output flush_req,
        input  lu_hit, lu_data, flush_busy
    );

    modport slave (
        input  lu_en, lu_addr,
        input  fill_strobe, fill_addr, fill_data,
        input  wr_strobe, wr_addr, wr_bsel, wr_data,
        input  flush_req,
        output lu_hit, lu_data, flush_busy
    );
endinterface

// File: rtl/zcache.sv
// zcache: parametrised read cache for the Z80 memory manager.
// Direct-mapped or 2-way (per-set LRU) word cache with registered
// single-cycle lookups, fills from DRAM read strobes, CPU write handling
// (invalidate or byte update) and a self-timed flush sweep that also
// initialises the reset-less tag RAM after reset.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : zcache_if.slave (lookup, fill, write, flush signals)
module zcache #(
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned WAYS   = 1,
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned WR_UPD = 0
) (
    input  logic     clk,
    input  logic     rst,
    zcache_if.slave  bus
);

    localparam int unsigned SETS  = 1 << IDX_W;
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // Storage: {valid, tag} and data per way, no reset.
    logic [TAG_W:0] tag_ram  [WAYS][SETS];
    logic [15:0]    data_ram [WAYS][SETS];

    // Flush FSM state
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             sweep_c;
    logic [IDX_W-1:0] cnt_idx;

    // Address fields
    logic [IDX_W-1:0] lu_idx, fill_idx, wr_idx;
    logic [TAG_W-1:0] lu_tag, fill_tag, wr_tag;

    // Lookup / fill / write decode
    logic       lu_any, lu_way, lu_hit_c;
    logic       fill_found, fill_way, fill_en_c;
    logic       wr_any, wr_way, wr_hit_en_c;
    logic       victim_c;

    // Registered lookup result
    logic        lu_hit_q;
    logic [15:0] lu_data_q;

    assign lu_idx   = bus.lu_addr[IDX_W-1:0];
    assign lu_tag   = bus.lu_addr[ADDR_W-1:IDX_W];
    assign fill_idx = bus.fill_addr[IDX_W-1:0];
    assign fill_tag = bus.fill_addr[ADDR_W-1:IDX_W];
    assign wr_idx   = bus.wr_addr[IDX_W-1:0];
    assign wr_tag   = bus.wr_addr[ADDR_W-1:IDX_W];

    assign sweep_c = (state_q == ST_SWEEP);
    assign cnt_idx = cnt_q[IDX_W-1:0];

    // Flush FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_SWEEP);
        end
    end

    // Flush FSM: next state; a request during the sweep restarts it at set 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (bus.flush_req) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Lookup tag compare (lowest matching way)
    always_comb begin
        lu_any = 1'b0;
        lu_way = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!lu_any && (tag_ram[1'(w)][lu_idx] == {1'b1, lu_tag})) begin
                lu_any = 1'b1;
                lu_way = 1'(w);
            end
        end
    end

    assign lu_hit_c = bus.lu_en && !sweep_c && lu_any;

    // Fill way choice: matching tag, else first invalid, else LRU victim
    always_comb begin
        fill_found = 1'b0;
        fill_way   = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!fill_found && (tag_ram[1'(w)][fill_idx] == {1'b1, fill_tag})) begin
                fill_found = 1'b1;
                fill_way   = 1'(w);
            end
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!fill_found && !tag_ram[1'(w)][fill_idx][TAG_W]) begin
                fill_found = 1'b1;
                fill_way   = 1'(w);
            end
        end
        if (!fill_found) begin
            fill_way = victim_c;
        end
    end

    // Write hit detection
    always_comb begin
        wr_any = 1'b0;
        wr_way = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!wr_any && (tag_ram[1'(w)][wr_idx] == {1'b1, wr_tag})) begin
                wr_any = 1'b1;
                wr_way = 1'(w);
            end
        end
    end

    // A write in the same cycle drops the fill regardless of address
    assign fill_en_c   = bus.fill_strobe && !sweep_c && !bus.wr_strobe;
    assign wr_hit_en_c = bus.wr_strobe && !sweep_c && wr_any;

    // Tag RAM writes
    always_ff @(posedge clk) begin
        if (sweep_c) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                tag_ram[1'(w)][cnt_idx] <= '0;
            end
        end else begin
            if (wr_hit_en_c && (WR_UPD == 0)) begin
                tag_ram[wr_way][wr_idx][TAG_W] <= 1'b0;
            end
            if (fill_en_c) begin
                tag_ram[fill_way][fill_idx] <= {1'b1, fill_tag};
            end
        end
    end

    // Data RAM writes
    always_ff @(posedge clk) begin
        if (!sweep_c) begin
            if (wr_hit_en_c && (WR_UPD != 0)) begin
                if (bus.wr_bsel) begin
                    data_ram[wr_way][wr_idx][15:8] <= bus.wr_data;
                end else begin
                    data_ram[wr_way][wr_idx][7:0] <= bus.wr_data;
                end
            end
            if (fill_en_c) begin
                data_ram[fill_way][fill_idx] <= bus.fill_data;
            end
        end
    end

    // Per-set LRU; fill update is applied last so it wins over a lookup hit
    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q, lru_d;

        always_comb begin
            lru_d = lru_q;
            if (sweep_c) begin
                lru_d[cnt_idx] = 1'b0;
            end else begin
                if (lu_hit_c) begin
                    lru_d[lu_idx] = ~lu_way;
                end
                if (fill_en_c) begin
                    lru_d[fill_idx] = ~fill_way;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lru_q <= '0;
            end else begin
                lru_q <= lru_d;
            end
        end

        assign victim_c = lru_q[fill_idx];
    end else begin : g_no_lru
        assign victim_c = 1'b0;
    end

    // Registered lookup result; data holds on a miss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_hit_q  <= 1'b0;
            lu_data_q <= '0;
        end else begin
            lu_hit_q <= lu_hit_c;
            if (lu_hit_c) begin
                lu_data_q <= data_ram[lu_way][lu_idx];
            end
        end
    end

    assign bus.lu_hit     = lu_hit_q;
    assign bus.lu_data    = lu_data_q;
    assign bus.flush_busy = busy_q;

endmodule

// File: tb/tb_zcache.sv
// tb_zcache: directed test of zcache in two configurations driven in
// lockstep: u_dut0 (1 way, invalidate on write) and u_dut1 (2 ways with
// LRU, byte update on write).
module tb_zcache;

    logic        clk;
    logic        rst;
    logic        lu_en;
    logic [20:0] lu_addr;
    logic        fill_strobe;
    logic [20:0] fill_addr;
    logic [15:0] fill_data;
    logic        wr_strobe;
    logic [20:0] wr_addr;
    logic        wr_bsel;
    logic [7:0]  wr_data;
    logic        flush_req;

    int n_checks = 0;
    int n_fail   = 0;

    zcache_if #(.ADDR_W(21)) bus0 ();
    zcache_if #(.ADDR_W(21)) bus1 ();

    assign bus0.lu_en = lu_en;             assign bus1.lu_en = lu_en;
    assign bus0.lu_addr = lu_addr;         assign bus1.lu_addr = lu_addr;
    assign bus0.fill_strobe = fill_strobe; assign bus1.fill_strobe = fill_strobe;
    assign bus0.fill_addr = fill_addr;     assign bus1.fill_addr = fill_addr;
    assign bus0.fill_data = fill_data;     assign bus1.fill_data = fill_data;
    assign bus0.wr_strobe = wr_strobe;     assign bus1.wr_strobe = wr_strobe;
    assign bus0.wr_addr = wr_addr;         assign bus1.wr_addr = wr_addr;
    assign bus0.wr_bsel = wr_bsel;         assign bus1.wr_bsel = wr_bsel;
    assign bus0.wr_data = wr_data;         assign bus1.wr_data = wr_data;
    assign bus0.flush_req = flush_req;     assign bus1.flush_req = flush_req;

    zcache #(.IDX_W(8), .WAYS(1), .ADDR_W(21), .WR_UPD(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    zcache #(.IDX_W(8), .WAYS(2), .ADDR_W(21), .WR_UPD(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fill(input logic [20:0] a, input logic [15:0] d);
        fill_strobe = 1'b1; fill_addr = a; fill_data = d;
        step();
        fill_strobe = 1'b0;
    endtask

    task automatic do_write(input logic [20:0] a, input logic b, input logic [7:0] d);
        wr_strobe = 1'b1; wr_addr = a; wr_bsel = b; wr_data = d;
        step();
        wr_strobe = 1'b0;
    endtask

    task automatic do_lookup(input logic [20:0] a);
        lu_en = 1'b1; lu_addr = a;
        step();
        lu_en = 1'b0;
    endtask

    // Counts cycles until flush_busy of u_dut0 drops, bounded
    task automatic count_busy(output int n);
        n = 0;
        while (bus0.flush_busy && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        int bad_hit;
        step(); step();
        n_checks++;
        if ({bus0.flush_busy, bus0.lu_hit, bus0.lu_data} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL reset_u0: busy/hit/data=%b/%b/%h want 1/0/0000", bus0.flush_busy, bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.flush_busy, bus1.lu_hit, bus1.lu_data} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL reset_u1: busy/hit/data=%b/%b/%h want 1/0/0000", bus1.flush_busy, bus1.lu_hit, bus1.lu_data);
        end
        rst = 1'b0;
        lu_en = 1'b1; lu_addr = 21'h000123;
        n = 0; bad_hit = 0;
        while (bus0.flush_busy && n < 2000) begin
            step();
            n++;
            if (bus0.lu_hit || bus1.lu_hit) bad_hit++;
        end
        n_checks++;
        if (n !== 256) begin
            n_fail++; $display("FAIL init_sweep_len: busy cycles=%0d want 256", n);
        end
        n_checks++;
        if (bad_hit !== 0) begin
            n_fail++; $display("FAIL init_sweep_hit: hits during sweep=%0d want 0", bad_hit);
        end
        n_checks++;
        if (bus1.flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL init_sweep_u1: busy=%b want 0", bus1.flush_busy);
        end
        step();
        lu_en = 1'b0;
        n_checks++;
        if ({bus0.lu_hit, bus1.lu_hit} !== 2'b00) begin
            n_fail++; $display("FAIL post_init_miss: hit u0/u1=%b/%b want 0/0", bus0.lu_hit, bus1.lu_hit);
        end
    endtask

    task automatic test_fill_hit();
        do_fill(21'h012345, 16'hBEEF);
        do_lookup(21'h012345);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b1, 16'hBEEF}) begin
            n_fail++; $display("FAIL fill_hit_u0: hit/data=%b/%h want 1/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'hBEEF}) begin
            n_fail++; $display("FAIL fill_hit_u1: hit/data=%b/%h want 1/beef", bus1.lu_hit, bus1.lu_data);
        end
        do_lookup(21'h112345);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL tag_miss_u0: hit/data=%b/%h want 0/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL tag_miss_u1: hit/data=%b/%h want 0/beef", bus1.lu_hit, bus1.lu_data);
        end
    endtask

    task automatic test_write_policy();
        do_write(21'h012345, 1'b1, 8'h5A);
        do_lookup(21'h012345);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_inval_u0: hit/data=%b/%h want 0/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'h5AEF}) begin
            n_fail++; $display("FAIL wr_upd_u1: hit/data=%b/%h want 1/5aef", bus1.lu_hit, bus1.lu_data);
        end
        do_write(21'h112345, 1'b0, 8'h11);
        do_lookup(21'h012345);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_miss_u0: hit/data=%b/%h want 0/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'h5AEF}) begin
            n_fail++; $display("FAIL wr_miss_u1: hit/data=%b/%h want 1/5aef", bus1.lu_hit, bus1.lu_data);
        end
    endtask

    task automatic test_lru();
        do_fill(21'h000010, 16'hAAAA);
        do_fill(21'h100010, 16'hBBBB);
        do_lookup(21'h000010);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL lru_a1_u0: hit/data=%b/%h want 0/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'hAAAA}) begin
            n_fail++; $display("FAIL lru_a1_u1: hit/data=%b/%h want 1/aaaa", bus1.lu_hit, bus1.lu_data);
        end
        do_fill(21'h080010, 16'hCCCC);
        do_lookup(21'h000010);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data} !== {1'b0, 16'hBEEF}) begin
            n_fail++; $display("FAIL lru_a2_u0: hit/data=%b/%h want 0/beef", bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'hAAAA}) begin
            n_fail++; $display("FAIL lru_a2_u1: hit/data=%b/%h want 1/aaaa", bus1.lu_hit, bus1.lu_data);
        end
        do_lookup(21'h080010);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'hCCCC, 1'b1, 16'hCCCC}) begin
            n_fail++; $display("FAIL lru_c: u0 %b/%h u1 %b/%h want 1/cccc 1/cccc", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        do_lookup(21'h100010);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b0, 16'hCCCC, 1'b0, 16'hCCCC}) begin
            n_fail++; $display("FAIL lru_b_evicted: u0 %b/%h u1 %b/%h want 0/cccc 0/cccc", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
    endtask

    task automatic test_collision();
        do_fill(21'h000020, 16'h1234);
        do_lookup(21'h000020);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'h1234, 1'b1, 16'h1234}) begin
            n_fail++; $display("FAIL coll_pre: u0 %b/%h u1 %b/%h want 1/1234 1/1234", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        // Fill and write to the same address: write wins
        fill_strobe = 1'b1; fill_addr = 21'h000020; fill_data = 16'h9999;
        do_write(21'h000020, 1'b0, 8'h77);
        fill_strobe = 1'b0;
        do_lookup(21'h000020);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b0, 16'h1234, 1'b1, 16'h1277}) begin
            n_fail++; $display("FAIL coll_same: u0 %b/%h u1 %b/%h want 0/1234 1/1277", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        // Fill dropped even when the write misses elsewhere
        fill_strobe = 1'b1; fill_addr = 21'h000030; fill_data = 16'h5555;
        do_write(21'h000040, 1'b0, 8'h66);
        fill_strobe = 1'b0;
        do_lookup(21'h000030);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b0, 16'h1234, 1'b0, 16'h1277}) begin
            n_fail++; $display("FAIL coll_other: u0 %b/%h u1 %b/%h want 0/1234 0/1277", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        // Lookup in the fill cycle sees pre-fill contents
        lu_en = 1'b1; lu_addr = 21'h000050;
        do_fill(21'h000050, 16'h4321);
        lu_en = 1'b0;
        n_checks++;
        if ({bus0.lu_hit, bus1.lu_hit} !== 2'b00) begin
            n_fail++; $display("FAIL coll_lu_fill: hit u0/u1=%b/%b want 0/0", bus0.lu_hit, bus1.lu_hit);
        end
        do_lookup(21'h000050);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'h4321, 1'b1, 16'h4321}) begin
            n_fail++; $display("FAIL coll_after_fill: u0 %b/%h u1 %b/%h want 1/4321 1/4321", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        // Lookup hit on A and fill of C in set 0x10 together: fill's LRU wins
        lu_en = 1'b1; lu_addr = 21'h000010;
        do_fill(21'h080010, 16'hCDCD);
        lu_en = 1'b0;
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b0, 16'h4321, 1'b1, 16'hAAAA}) begin
            n_fail++; $display("FAIL lru_race_lu: u0 %b/%h u1 %b/%h want 0/4321 1/aaaa", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        do_fill(21'h100010, 16'hBBBB);
        do_lookup(21'h000010);
        n_checks++;
        if ({bus0.lu_hit, bus1.lu_hit} !== 2'b00) begin
            n_fail++; $display("FAIL lru_race_a: hit u0/u1=%b/%b want 0/0", bus0.lu_hit, bus1.lu_hit);
        end
        do_lookup(21'h080010);
        n_checks++;
        if ({bus0.lu_hit, bus1.lu_hit, bus1.lu_data} !== {1'b0, 1'b1, 16'hCDCD}) begin
            n_fail++; $display("FAIL lru_race_c: u0 hit %b u1 %b/%h want 0 1/cdcd", bus0.lu_hit, bus1.lu_hit, bus1.lu_data);
        end
        do_lookup(21'h100010);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'hBBBB, 1'b1, 16'hBBBB}) begin
            n_fail++; $display("FAIL lru_race_b: u0 %b/%h u1 %b/%h want 1/bbbb 1/bbbb", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
    endtask

    task automatic test_flush();
        int n;
        for (int k = 1; k <= 4; k++) do_fill(21'(k), 16'h1000 + 16'(k));
        do_lookup(21'h000003);
        n_checks++;
        if ({bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 16'h1003, 1'b1, 16'h1003}) begin
            n_fail++; $display("FAIL flush_pre: u0 %b/%h u1 %b/%h want 1/1003 1/1003", bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        flush_req = 1'b1; step(); flush_req = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 256 || bus1.flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_len: busy cycles=%0d u1 busy=%b want 256/0", n, bus1.flush_busy);
        end
        for (int k = 1; k <= 4; k++) begin
            do_lookup(21'(k));
            n_checks++;
            if ({bus0.lu_hit, bus1.lu_hit} !== 2'b00) begin
                n_fail++; $display("FAIL flush_miss_%0d: hit u0/u1=%b/%b want 0/0", k, bus0.lu_hit, bus1.lu_hit);
            end
        end
        // Re-request at cycle 100 of the sweep
        flush_req = 1'b1; step(); flush_req = 1'b0;
        n = 0;
        while (bus0.flush_busy && n < 2000) begin
            flush_req = (n == 99);
            step();
            n++;
        end
        flush_req = 1'b0;
        n_checks++;
        if (n !== 356) begin
            n_fail++; $display("FAIL flush_restart_len: busy cycles=%0d want 356", n);
        end
    endtask

    task automatic test_async_reset();
        int n;
        do_fill(21'h000001, 16'h1001);
        lu_en = 1'b1; lu_addr = 21'h000001; flush_req = 1'b1;
        step();
        lu_en = 1'b0; flush_req = 1'b0;
        n_checks++;
        if ({bus0.flush_busy, bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data} !== {1'b1, 1'b1, 16'h1001, 1'b1, 16'h1001}) begin
            n_fail++; $display("FAIL arst_pre: busy %b u0 %b/%h u1 %b/%h want 1 1/1001 1/1001", bus0.flush_busy, bus0.lu_hit, bus0.lu_data, bus1.lu_hit, bus1.lu_data);
        end
        step(); step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus0.flush_busy, bus0.lu_hit, bus0.lu_data} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL arst_u0: busy/hit/data=%b/%b/%h want 1/0/0000", bus0.flush_busy, bus0.lu_hit, bus0.lu_data);
        end
        n_checks++;
        if ({bus1.flush_busy, bus1.lu_hit, bus1.lu_data} !== {1'b1, 1'b0, 16'h0000}) begin
            n_fail++; $display("FAIL arst_u1: busy/hit/data=%b/%b/%h want 1/0/0000", bus1.flush_busy, bus1.lu_hit, bus1.lu_data);
        end
        step(); step();
        rst = 1'b0;
        count_busy(n);
        n_checks++;
        if (n !== 256) begin
            n_fail++; $display("FAIL arst_sweep_len: busy cycles=%0d want 256", n);
        end
        do_lookup(21'h000001);
        n_checks++;
        if ({bus0.lu_hit, bus1.lu_hit} !== 2'b00) begin
            n_fail++; $display("FAIL arst_miss: hit u0/u1=%b/%b want 0/0", bus0.lu_hit, bus1.lu_hit);
        end
    endtask

    initial begin
        rst = 1'b1;
        lu_en = 1'b0; lu_addr = '0;
        fill_strobe = 1'b0; fill_addr = '0; fill_data = '0;
        wr_strobe = 1'b0; wr_addr = '0; wr_bsel = 1'b0; wr_data = '0;
        flush_req = 1'b0;
        test_reset();
        test_fill_hit();
        test_write_policy();
        test_lru();
        test_collision();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zcache.md
# zcache

Parametrised read cache for the Z80 memory manager, sitting between the CPU-side page/window logic and the DRAM arbiter's CPU port. It generalises the 256-entry direct-mapped, invalidate-on-write cache: configurable depth and associativity (1 or 2 ways with per-set LRU), selectable write policy (invalidate or byte-update), and a self-timed flush engine. The flush engine also initialises the reset-less tag RAM after reset. Lookups are single-cycle pipelined; fills come from DRAM read strobes; writes come from CPU write cycles.

## Interface
- IDX_W, 8, set index width; 2^IDX_W sets.
- WAYS, 1, associativity; legal values are 1 and 2.
- ADDR_W, 21, 16-bit-word address width, {page, za[13:1]}.
- WR_UPD, 0, write-hit policy: 0 invalidates the entry, 1 updates the addressed byte.
- TAG_W is derived as ADDR_W-IDX_W.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- lu_addr  in  ADDR_W  lookup word address.
- lu_en  in  1  lookup enable (the per-window cache_en is already applied).
- lu_hit  out  1  registered hit for the previous cycle's lookup.
- lu_data  out  16  registered word for the previous cycle's lookup.
- fill_strobe  in  1  DRAM read data valid (cpu_strobe).
- fill_addr  in  ADDR_W  word address of the fill.
- fill_data  in  16  word from DRAM.
- wr_strobe  in  1  one-cycle CPU RAM write pulse (memwr_s and write-enabled).
- wr_addr  in  ADDR_W  word address of the write.
- wr_bsel  in  1  0 selects byte [7:0], 1 selects byte [15:8].
- wr_data  in  8  written byte.
- flush_req  in  1  request to invalidate the whole cache.
- flush_busy  out  1  flush in progress.

## Operation
- Address split:
  - index = addr[IDX_W-1:0]
  - tag = addr[ADDR_W-1:IDX_W]
- Storage per way:
  - Tag RAM entry {valid, tag} of width 1+TAG_W.
  - Data RAM entry of 16 bits.
  - Both are synchronous-write, read address unregistered, output registered.
  - Neither RAM has a reset.
- LRU storage: with WAYS=2, one LRU flop per set, reset to 0. LRU=w means way w is the next victim.

Lookup
- lu_addr is sampled at edge N.
- At N+1, lu_hit = lu_en(N) && !flush_busy(N) && a way holds valid with matching tag.
- lu_data is the data of the hitting way; when there is no hit it holds its previous value.
- With WAYS=2, a hit sets LRU[index] to the other way.

Fill (fill_strobe && !flush_busy && !wr_strobe)
- Way choice, in priority order:
  1. A way whose valid tag equals the fill tag.
  2. Otherwise the first invalid way, starting from way 0.
  3. Otherwise way LRU[index].
- Writes {1, tag} and fill_data into the chosen way.
- With WAYS=2, sets LRU to the other way.

Write (wr_strobe && !flush_busy)
- Write miss: no change.
- Write hit, WR_UPD=0: clear valid of the hit way.
- Write hit, WR_UPD=1: replace the byte selected by wr_bsel; tag, valid and LRU are unchanged.

Flush FSM
- States: IDLE and SWEEP.
- IDLE to SWEEP on flush_req; the counter cnt is loaded with 0.
- In SWEEP, each cycle writes valid=0 to set cnt in all ways, clears LRU[cnt], then increments cnt.
- SWEEP returns to IDLE after set 2^IDX_W-1 is written.
- flush_req during SWEEP restarts cnt at 0.
- While in SWEEP: fills and writes are dropped, and lu_hit is 0.

## Timing
- Reset values:
  - State SWEEP, cnt=0, flush_busy=1.
  - lu_hit=0, lu_data=16'h0000, all LRU=0.
  - The sweep starts at the first clock after rst deasserts and lasts exactly 2^IDX_W cycles; default 256.
- Lookup latency is 1 clock, which matches DRAM q timing, so the memory manager can choose cpu_rddata or lu_data on cpu_latch.
- Same-edge hazard: a lookup at edge N sees contents before any fill, write or flush applied at N. The caller must not rely on same-cycle forwarding.
- Simultaneous fill and write at the same edge: the write wins and the fill is dropped, whichever sets they address. The next read misses and refills.
- Fill and lookup to the same set at the same edge: the lookup returns the old contents, and the fill's LRU update wins over the lookup's.
- rst asserted mid-sweep or mid-operation asynchronously restores all reset values, and the sweep restarts from set 0.
- Counter wrap: cnt is IDX_W+1 bits wide; the terminal test is cnt == 2^IDX_W-1.

## Test plan
- Reset and init: release rst, probe lookups during the sweep -> flush_busy stays 1 for exactly 256 clocks and lu_hit is 0 throughout. After the sweep, a lookup at 21'h000123 -> lu_hit=0.
- Fill then hit: fill 21'h012345 with 16'hBEEF, then lookup the same address -> lu_hit=1 and lu_data=16'hBEEF one clock later. Lookup 21'h112345 -> lu_hit=0.
- Write policy:
  - WR_UPD=0: write byte 1 of 21'h012345 -> the next lookup misses.
  - WR_UPD=1: write 8'h5A to byte 1 -> lu_data=16'h5AEF. A write to 21'h112345 leaves 16'h5AEF intact.
- Two-way LRU (WAYS=2):
  - Fill A=21'h000010 and B=21'h100010, then look up A.
  - Fill C=21'h080010 -> C evicts B; A and C hit, B misses.
- Collisions: fill_strobe and wr_strobe in the same cycle to the same address -> the fill is dropped and the entry keeps its prior state. A lookup in the same cycle as a fill returns the pre-fill result.
- Flush and async reset:
  - Fill 4 sets, pulse flush_req -> 256 busy cycles, then all 4 miss.
  - Pulse flush_req again at cycle 100 of the sweep -> the sweep is extended to finish at cycle 356.
  - Assert rst mid-sweep -> flush_busy=1 and cnt=0 immediately, without waiting for a clock edge.
